// File: rtl/rename_rat_if.sv
// Rename stage bus: decode bundle in, freelist grants, dispatch out, retire.
// Driven by the environment (master) and consumed by rename_rat (slave).
interface rename_rat_if #(
  parameter int ARCH_WIDTH = 5,
  parameter int PHY_WIDTH  = 6
);
  logic                  flush;
  logic [1:0]            in_valid;
  logic                  in_ready;
  logic [ARCH_WIDTH-1:0] rs1_0, rs2_0, rd_0;
  logic                  rd_we_0;
  logic [ARCH_WIDTH-1:0] rs1_1, rs2_1, rd_1;
  logic                  rd_we_1;
  logic [PHY_WIDTH:0]    free_count;
  logic [1:0]            alloc_valid;
  logic [PHY_WIDTH-1:0]  phy_new_0, phy_new_1;
  logic [1:0]            out_valid;
  logic                  out_ready;
  logic [PHY_WIDTH-1:0]  out_rs1_phy_0, out_rs2_phy_0;
  logic [PHY_WIDTH-1:0]  out_rd_phy_new_0, out_rd_phy_old_0;
  logic [PHY_WIDTH-1:0]  out_rs1_phy_1, out_rs2_phy_1;
  logic [PHY_WIDTH-1:0]  out_rd_phy_new_1, out_rd_phy_old_1;
  logic                  retire_valid;
  logic [ARCH_WIDTH-1:0] retire_rd_arch;
  logic [PHY_WIDTH-1:0]  retire_rd_phy_new;

  modport slave (
    input  flush, in_valid,
    input  rs1_0, rs2_0, rd_0, rd_we_0,
    input  rs1_1, rs2_1, rd_1, rd_we_1,
    input  free_count, phy_new_0, phy_new_1,
    input  out_ready,
    input  retire_valid, retire_rd_arch,
    input  retire_rd_phy_new,
    output in_ready, alloc_valid, out_valid,
    output out_rs1_phy_0, out_rs2_phy_0,
    output out_rd_phy_new_0, out_rd_phy_old_0,
    output out_rs1_phy_1, out_rs2_phy_1,
    output out_rd_phy_new_1, out_rd_phy_old_1
  );

  modport master (
    output flush, in_valid,
    output rs1_0, rs2_0, rd_0, rd_we_0,
    output rs1_1, rs2_1, rd_1, rd_we_1,
    output free_count, phy_new_0, phy_new_1,
    output out_ready,
    output retire_valid, retire_rd_arch,
    output retire_rd_phy_new,
    input  in_ready, alloc_valid, out_valid,
    input  out_rs1_phy_0, out_rs2_phy_0,
    input  out_rd_phy_new_0, out_rd_phy_old_0,
    input  out_rs1_phy_1, out_rs2_phy_1,
    input  out_rd_phy_new_1, out_rd_phy_old_1
  );
endinterface

// File: rtl/rename_rat.sv
// Two-wide rename with speculative RAT, committed RAT and flush restore.
// Optional RENAME_EXACT_STALL_EN: stall only on the registers actually needed.
module rename_rat #(
  parameter int ARCH_REGS  = 32,
  parameter int ARCH_WIDTH = 5,
  parameter int PHY_WIDTH  = 6
) (
  input logic         clk,
  input logic         rst,
  rename_rat_if.slave bus
);
  typedef logic [PHY_WIDTH-1:0] phy_t;

  typedef struct packed {
    logic [1:0] v;
    phy_t s1_0, s2_0, new_0, old_0;
    phy_t s1_1, s2_1, new_1, old_1;
  } out_t;

  phy_t rat_q [ARCH_REGS];
  phy_t rat_d [ARCH_REGS];
  phy_t crat_q [ARCH_REGS];
  phy_t crat_d [ARCH_REGS];
  out_t out_q, out_d;

  logic need0, need1, cnt_ok, ready, fire;
  phy_t g0, g1;
  phy_t s1p1, s2p1, old1;

  assign need0 = bus.in_valid[0] && bus.rd_we_0
              && (bus.rd_0 != '0);
  assign need1 = bus.in_valid[1] && bus.rd_we_1
              && (bus.rd_1 != '0);

`ifdef RENAME_EXACT_STALL_EN
  logic [PHY_WIDTH:0] req;
  assign req = (PHY_WIDTH+1)'(need0)
             + (PHY_WIDTH+1)'(need1);
  assign cnt_ok = bus.free_count >= req;
`else
  assign cnt_ok = bus.free_count
               >= (PHY_WIDTH+1)'(2);
`endif

  assign ready = !rst && !bus.flush
              && (out_q.v == 2'b00 || bus.out_ready)
              && cnt_ok;
  assign fire = (|bus.in_valid) && ready;

  assign bus.in_ready    = ready;
  assign bus.alloc_valid = {fire && need1,
                            fire && need0};

  // freelist hands slot 1 the head grant when slot 0 takes nothing
  assign g0 = bus.phy_new_0;
  assign g1 = need0 ? bus.phy_new_1 : bus.phy_new_0;

  assign s1p1 = (need0 && bus.rs1_1 == bus.rd_0)
              ? g0 : rat_q[bus.rs1_1];
  assign s2p1 = (need0 && bus.rs2_1 == bus.rd_0)
              ? g0 : rat_q[bus.rs2_1];
  assign old1 = (need0 && bus.rd_1 == bus.rd_0)
              ? g0 : rat_q[bus.rd_1];

  always_comb begin
    crat_d = crat_q;
    if (bus.retire_valid
        && bus.retire_rd_arch != '0)
      crat_d[bus.retire_rd_arch] =
        bus.retire_rd_phy_new;
    rat_d = rat_q;
    if (bus.flush) begin
      rat_d = crat_d;
    end else if (fire) begin
      if (need0) rat_d[bus.rd_0] = g0;
      if (need1) rat_d[bus.rd_1] = g1;
    end
  end

  always_comb begin
    out_d = out_q;
    if (bus.flush) begin
      out_d = '0;
    end else if (fire) begin
      out_d.v     = bus.in_valid;
      out_d.s1_0  = rat_q[bus.rs1_0];
      out_d.s2_0  = rat_q[bus.rs2_0];
      out_d.old_0 = rat_q[bus.rd_0];
      out_d.new_0 = need0 ? g0 : '0;
      out_d.s1_1  = s1p1;
      out_d.s2_1  = s2p1;
      out_d.old_1 = old1;
      out_d.new_1 = need1 ? g1 : '0;
    end else if (bus.out_ready) begin
      out_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat_q[i]  <= PHY_WIDTH'(i);
        crat_q[i] <= PHY_WIDTH'(i);
      end
      out_q <= '0;
    end else begin
      rat_q  <= rat_d;
      crat_q <= crat_d;
      out_q  <= out_d;
    end
  end

  assign bus.out_valid        = out_q.v;
  assign bus.out_rs1_phy_0    = out_q.s1_0;
  assign bus.out_rs2_phy_0    = out_q.s2_0;
  assign bus.out_rd_phy_new_0 = out_q.new_0;
  assign bus.out_rd_phy_old_0 = out_q.old_0;
  assign bus.out_rs1_phy_1    = out_q.s1_1;
  assign bus.out_rs2_phy_1    = out_q.s2_1;
  assign bus.out_rd_phy_new_1 = out_q.new_1;
  assign bus.out_rd_phy_old_1 = out_q.old_1;
endmodule

// File: tb/tb_rename_rat.sv
// Scoreboard bench for rename_rat: directed bundles then random traffic
// against a sequential-rename reference model.
module tb_rename_rat;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rename_rat_if bus ();
  rename_rat dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [1:0] v;
    logic [1:0][5:0] s1, s2, nw, od;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int rat [32];
  int crat [32];
  bit occ;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      rat[i] = i;
      crat[i] = i;
    end
    occ = 1'b0;
  endtask

  task automatic set_b(
    input logic [1:0] v,
    input int a0, input int b0, input int d0,
    input bit w0,
    input int a1, input int b1, input int d1,
    input bit w1,
    input int p0, input int p1);
    bus.in_valid = v;
    bus.rs1_0 = 5'(a0); bus.rs2_0 = 5'(b0);
    bus.rd_0 = 5'(d0); bus.rd_we_0 = w0;
    bus.rs1_1 = 5'(a1); bus.rs2_1 = 5'(b1);
    bus.rd_1 = 5'(d1); bus.rd_we_1 = w1;
    bus.phy_new_0 = 6'(p0);
    bus.phy_new_1 = 6'(p1);
  endtask

  // rename as if the two slots were processed one after the other
  task automatic cycle();
    bit n0, n1, ok, rdy, fire;
    int need, g1;
    int tmp [32];
    exp_t e;
    n0 = bus.in_valid[0] && bus.rd_we_0
      && bus.rd_0 != 0;
    n1 = bus.in_valid[1] && bus.rd_we_1
      && bus.rd_1 != 0;
    need = int'(n0) + int'(n1);
`ifdef RENAME_EXACT_STALL_EN
    ok = int'(bus.free_count) >= need;
`else
    ok = int'(bus.free_count) >= 2;
`endif
    rdy = !rst && !bus.flush
       && (!occ || bus.out_ready) && ok;
    fire = rdy && bus.in_valid != 0;
    @(negedge clk);
    chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    chk("alloc_valid", 32'(bus.alloc_valid),
        32'({fire && n1, fire && n0}));
    tmp = rat;
    if (fire) begin
      e = '0;
      e.v = bus.in_valid;
      e.s1[0] = 6'(tmp[bus.rs1_0]);
      e.s2[0] = 6'(tmp[bus.rs2_0]);
      e.od[0] = 6'(tmp[bus.rd_0]);
      e.nw[0] = n0 ? bus.phy_new_0 : 6'd0;
      if (n0) tmp[bus.rd_0] = int'(bus.phy_new_0);
      g1 = n0 ? int'(bus.phy_new_1)
              : int'(bus.phy_new_0);
      e.s1[1] = 6'(tmp[bus.rs1_1]);
      e.s2[1] = 6'(tmp[bus.rs2_1]);
      e.od[1] = 6'(tmp[bus.rd_1]);
      e.nw[1] = n1 ? 6'(g1) : 6'd0;
      if (n1) tmp[bus.rd_1] = g1;
      q.push_back(e);
    end
    if (rst) begin
      model_reset();
    end else begin
      if (bus.retire_valid && bus.retire_rd_arch != 0)
        crat[bus.retire_rd_arch] =
          int'(bus.retire_rd_phy_new);
      if (bus.flush) begin
        rat = crat;
        occ = 1'b0;
      end else if (fire) begin
        rat = tmp;
        occ = 1'b1;
      end else if (bus.out_ready) begin
        occ = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    bit held;
    exp_t e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (bus.out_valid != 0 && !held) begin
          if (q.size() == 0) begin
            chk("unexpected_out", 32'(bus.out_valid), 0);
          end else begin
            e = q.pop_front();
            chk("out_valid", 32'(bus.out_valid), 32'(e.v));
            if (e.v[0]) begin
              chk("rs1_0", 32'(bus.out_rs1_phy_0), 32'(e.s1[0]));
              chk("rs2_0", 32'(bus.out_rs2_phy_0), 32'(e.s2[0]));
              chk("new_0", 32'(bus.out_rd_phy_new_0), 32'(e.nw[0]));
              chk("old_0", 32'(bus.out_rd_phy_old_0), 32'(e.od[0]));
            end
            if (e.v[1]) begin
              chk("rs1_1", 32'(bus.out_rs1_phy_1), 32'(e.s1[1]));
              chk("rs2_1", 32'(bus.out_rs2_phy_1), 32'(e.s2[1]));
              chk("new_1", 32'(bus.out_rd_phy_new_1), 32'(e.nw[1]));
              chk("old_1", 32'(bus.out_rd_phy_old_1), 32'(e.od[1]));
            end
          end
          held = 1'b1;
        end
        if (bus.out_ready || bus.flush) held = 1'b0;
      end
    end
  end

  initial begin
    model_reset();
    set_b(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.flush = 1'b0;
    bus.free_count = 7'd64;
    bus.out_ready = 1'b1;
    bus.retire_valid = 1'b0;
    bus.retire_rd_arch = '0;
    bus.retire_rd_phy_new = '0;
    rst = 1'b1;
    #1;
    cycle();
    cycle();
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_new_0", 32'(bus.out_rd_phy_new_0), 0);
    chk("rst_rs1_1", 32'(bus.out_rs1_phy_1), 0);
    rst = 1'b0;

    set_b(2'b11, 1, 0, 5, 1, 5, 0, 6, 1, 32, 33);
    cycle();
    set_b(2'b11, 0, 0, 7, 1, 5, 6, 7, 1, 34, 35);
    cycle();
    set_b(2'b01, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    set_b(2'b11, 1, 2, 0, 0, 4, 0, 3, 1, 36, 37);
    cycle();
    set_b(2'b11, 0, 0, 0, 1, 0, 5, 0, 1, 38, 39);
    cycle();

    set_b(2'b01, 0, 0, 5, 1, 0, 0, 0, 0, 32, 0);
    cycle();
    set_b(2'b01, 0, 0, 5, 1, 0, 0, 0, 0, 40, 0);
    bus.retire_valid = 1'b1;
    bus.retire_rd_arch = 5'd5;
    bus.retire_rd_phy_new = 6'd32;
    cycle();
    bus.retire_valid = 1'b0;
    set_b(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("ov_flush_cycle", 32'(bus.out_valid), 0);
    bus.flush = 1'b1;
    set_b(2'b01, 5, 0, 9, 1, 0, 0, 0, 0, 44, 0);
    cycle();
    bus.flush = 1'b0;
    chk("ov_after_flush", 32'(bus.out_valid), 0);
    set_b(2'b01, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();

    bus.out_ready = 1'b0;
    set_b(2'b01, 0, 0, 9, 1, 0, 0, 0, 0, 41, 0);
    cycle();
    set_b(2'b01, 9, 0, 10, 1, 0, 0, 0, 0, 42, 0);
    cycle();
    bus.out_ready = 1'b1;
    cycle();
    bus.free_count = 7'd1;
    set_b(2'b01, 9, 0, 11, 1, 0, 0, 0, 0, 43, 0);
    cycle();
    set_b(2'b11, 11, 0, 0, 0, 9, 0, 0, 1, 0, 0);
    cycle();
    bus.free_count = 7'd64;

    for (int n = 0; n < 3000; n++) begin
      set_b(2'($urandom),
            $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), 1'($urandom),
            $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), 1'($urandom),
            $urandom_range(1, 63), $urandom_range(1, 63));
      if ($urandom_range(0, 20) == 0) begin
        set_b(2'b11, $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), 1'b1,
              $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), 1'b1,
              $urandom_range(1, 63), $urandom_range(1, 63));
      end
      bus.free_count = ($urandom_range(0, 3) == 0)
                     ? 7'($urandom_range(0, 3)) : 7'd64;
      bus.out_ready = $urandom_range(0, 3) != 0;
      bus.flush = $urandom_range(0, 19) == 0;
      bus.retire_valid = 1'($urandom);
      bus.retire_rd_arch = 5'($urandom_range(0, 7));
      bus.retire_rd_phy_new = 6'($urandom_range(1, 63));
      cycle();
    end

    set_b(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    bus.retire_valid = 1'b0;
    bus.free_count = 7'd64;
    for (int n = 0; n < 4; n++) cycle();
    chk("queue_drained", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rename_rat.md
# rename_rat

Two-wide register-rename stage sitting directly upstream of the physical-register freelist. It looks up source mappings in a speculative register alias table, requests new destination registers from the freelist, resolves dependencies inside the bundle, and registers the renamed bundle for dispatch. A committed RAT, updated at retire, restores the speculative map on flush.

## Interface
- ARCH_REGS, 32, architectural registers
- ARCH_WIDTH, 5, architectural index width
- PHY_REGS, 64, physical registers
- PHY_WIDTH, 6, physical index width
- clk  in  1  clock; every state change on the rising edge
- rst  in  1  reset; synchronous, active-high
- flush  in  1  pipeline flush; restore speculative RAT from committed RAT
- in_valid  in  2  slot valid; bit0 = older slot 0, bit1 = slot 1
- in_ready  out  1  bundle accepted this cycle when high and |in_valid
- rs1_0, rs2_0, rd_0  in  ARCH_WIDTH each  slot-0 architectural operands
- rd_we_0  in  1  slot 0 writes rd_0
- rs1_1, rs2_1, rd_1, rd_we_1  in  same as slot 0  slot-1 operands
- free_count  in  PHY_WIDTH+1  free physical registers currently available in the freelist
- alloc_valid  out  2  freelist allocate request, one bit per slot
- phy_new_0, phy_new_1  in  PHY_WIDTH  freelist grants for slot 0 and slot 1
- out_valid  out  2  registered renamed slots
- out_ready  in  1  dispatch consumes the output register
- out_rs1_phy_0, out_rs2_phy_0, out_rd_phy_new_0, out_rd_phy_old_0  out  PHY_WIDTH each  slot-0 results
- out_rs1_phy_1, out_rs2_phy_1, out_rd_phy_new_1, out_rd_phy_old_1  out  PHY_WIDTH each  slot-1 results
- retire_valid  in  1  one instruction retires
- retire_rd_arch  in  ARCH_WIDTH  retiring destination
- retire_rd_phy_new  in  PHY_WIDTH  retiring new mapping

## Operation
- Slot i needs a register (need_i) when in_valid[i] && rd_we_i && rd_i != 0. Architectural register 0 always maps to physical 0; it is never allocated and never remapped.
- fire = |in_valid && in_ready. alloc_valid[i] = fire && need_i. The freelist supplies phy_new_0 at head. It supplies phy_new_1 at head+1 when alloc_valid[0] is set, otherwise at head. The slot-1 grant is therefore taken from phy_new_0 when only slot 1 allocates.
- Slot-0 lookup: rsX_phy = RAT[rsX_0]; rd_phy_old = RAT[rd_0].
- Slot-1 lookup uses slot-0 bypass. If need_0 and rs1_1 == rd_0, slot 1 takes slot-0's new register; the same rule applies to rs2_1. If need_0 and rd_1 == rd_0, rd_phy_old_1 is slot-0's new register.
- On fire, the RAT is written for each slot with need_i. If both slots write the same rd, slot 1's value wins.
- out_rd_phy_new_i = 0 when need_i is low.
- Committed RAT: on retire_valid with retire_rd_arch != 0, CRAT[retire_rd_arch] <= retire_rd_phy_new.
- Flush: RAT <= CRAT, with any same-cycle retire write applied first. out_valid <= 0. alloc_valid is forced to 0. in_ready is 0 during flush.
- Output register:
  - loads on fire, with out_valid <= in_valid;
  - otherwise clears to 0 when out_ready is high;
  - otherwise holds.

## Timing
- Reset (synchronous): RAT[i] = i and CRAT[i] = i for all i. out_valid = 0 and all out_* = 0. in_ready is low during the reset cycle.
- in_ready = !rst && !flush && (out_valid == 0 || out_ready) && free_count >= 2 (see Configuration).
- Latency is one cycle, from fire to out_valid.
- Back-to-back bundles see each other's mappings: the RAT write and the output load occur on the same edge.
- alloc_valid is combinational in the fire cycle; the freelist advances head on that edge.
- Retire and fire in the same cycle update CRAT and RAT independently.
- Flush together with fire: flush wins, and no allocation occurs.

## Configuration
- RENAME_EXACT_STALL_EN
  - Defined: in_ready requires free_count >= need_0 + need_1, so a bundle needing zero or one register proceeds with fewer than 2 free.
  - Undefined: the conservative free_count >= 2 rule applies.
  - All other behaviour is identical.

## Test plan
- Reset, then bundle slot0 {rd=5, rs1=1}, slot1 {rd=6, rs1=5}, grants 32/33. Expected next cycle: out_rs1_phy_0=1, out_rd_phy_old_0=5, out_rd_phy_new_0=32, out_rs1_phy_1=32 (bypass), out_rd_phy_new_1=33. Then RAT[5]=32 and RAT[6]=33.
- Both slots write rd=7, grants 34/35. Expected: out_rd_phy_old_1=34, RAT[7]=35; a following bundle reading r7 gets 35.
- Only slot 1 writes rd=3 (slot0 rd_we=0). Expected: alloc_valid=2'b10, out_rd_phy_new_1 equals phy_new_0 input, out_rd_phy_new_0=0.
- rd=0 on both slots. Expected: alloc_valid=0, RAT unchanged, sources with index 0 read phy 0.
- Rename r5->32, retire (5,32), rename r5->40, then flush. Expected: the next lookup of r5 yields 32, out_valid=0 in the flush cycle and the cycle after, and in_ready=0 during flush.
- out_ready=0 with output full stalls: in_ready=0 and alloc_valid=0. free_count=1 with one needed register: in_ready=0 without the macro, 1 with RENAME_EXACT_STALL_EN.
